// File: rtl/sd_start_pkg.sv
// Shared definitions for the SD card start controller: state encoding,
// debug-word field offsets and the lowest-pressed-channel helper.
package sd_start_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ARMING = 4'd1,
      ST_START  = 4'd2,
      ST_WAIT   = 4'd3,
      ST_DONE   = 4'd4,
      ST_FAIL   = 4'd5
   } state_t;

   localparam int DBG_PRESS_LSB = 0;
   localparam int DBG_RETRY_LSB = 4;
   localparam int DBG_SEL_LSB   = 8;
   localparam int DBG_STATE_LSB = 12;

   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sd_start_tick_pulser.sv
// Per-button two-flop synchroniser sampled on tick, with a rising-edge pulse
// that lasts exactly one tick and ignores buttons already held at reset.
module tick_pulser
   import sd_start_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic pb,
   output logic press
);

   logic       s1_r;
   logic       s2_r;
   logic [1:0] vld_r;
   logic       armed_r;
   logic       armed_nxt_s;

   // A genuine low sample must be seen before any rising edge counts.
   assign armed_nxt_s = armed_r | (vld_r[1] & ~s2_r);

   // Synchroniser, fill tracking and registered edge pulse, all on tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_r    <= 1'b0;
         s2_r    <= 1'b0;
         vld_r   <= 2'b00;
         armed_r <= 1'b0;
         press   <= 1'b0;
      end else if (tick) begin
         s1_r    <= pb;
         s2_r    <= s1_r;
         vld_r   <= {vld_r[0], 1'b1};
         armed_r <= armed_nxt_s;
         press   <= s1_r & ~s2_r & armed_nxt_s;
      end
   end

endmodule

// File: rtl/sd_start_ctrl.sv
// Push-button start sequencer for NCH targets, stepping on a prescaled tick.
// Optional feature: define SD_START_RETRY_EN to restart after a done timeout.
module sd_start_ctrl
   import sd_start_pkg::*;
#(
   parameter int DIV_BITS      = 17,
   parameter int NCH           = 4,
   parameter int ARM_PRESSES   = 2,
   parameter int TIMEOUT_TICKS = 255,
   parameter int MAX_RETRY     = 3
) (
   input  logic            clk_raw,
   input  logic            reset,
   input  logic [NCH-1:0]  pb_raw,
   input  logic [NCH-1:0]  done_i,
   output logic [NCH-1:0]  start_o,
   output logic            busy,
   output logic            fail,
   output logic [15:0]     debug
);

`ifdef SD_START_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic [DIV_BITS-1:0] presc_r;
   logic                tick_s;
   logic [NCH-1:0]      press_s;
   state_t              state_r, state_nxt;
   logic [3:0]          sel_r, sel_nxt;
   logic [3:0]          cnt_r, cnt_nxt;
   logic [3:0]          retry_r, retry_nxt;
   logic [7:0]          timer_r, timer_nxt;
   logic                gap_r, gap_nxt;
   logic [NCH-1:0]      sel_mask_s, sel_mask_nxt_s, start_nxt_s;
   logic                press_any_s, press_sel_s, done_sel_s, timeout_s;
   logic [3:0]          cnt_inc_s;
   logic [7:0]          timer_inc_s;
   logic                busy_nxt_s, fail_nxt_s;
   logic [15:0]         debug_nxt_s;

   function automatic logic [NCH-1:0] onehot(input logic [3:0] idx);
      logic [NCH-1:0] m;
      for (int i = 0; i < NCH; i++) begin
         m[i] = (idx == 4'(i));
      end
      return m;
   endfunction

   // Free-running prescaler; its wrap is the only timebase for the FSM.
   always_ff @(posedge clk_raw or posedge reset) begin
      if (reset) begin
         presc_r <= {DIV_BITS{1'b0}};
      end else begin
         presc_r <= presc_r + DIV_BITS'(1);
      end
   end

   assign tick_s = (presc_r == {DIV_BITS{1'b1}});

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      tick_pulser u_pulser (
         .clk   (clk_raw),
         .reset (reset),
         .tick  (tick_s),
         .pb    (pb_raw[g]),
         .press (press_s[g])
      );
   end

   assign sel_mask_s  = onehot(sel_r);
   assign press_any_s = |press_s;
   assign press_sel_s = (press_s == sel_mask_s);
   assign done_sel_s  = |(done_i & sel_mask_s);
   assign timeout_s   = (timer_r >= 8'(TIMEOUT_TICKS - 1));
   assign cnt_inc_s   = (cnt_r == 4'hF) ? cnt_r : cnt_r + 4'd1;
   assign timer_inc_s = (timer_r == 8'hFF) ? timer_r : timer_r + 8'd1;

   // Next-state and counter updates; nothing moves between ticks.
   always_comb begin
      state_nxt = state_r;
      sel_nxt   = sel_r;
      cnt_nxt   = cnt_r;
      retry_nxt = retry_r;
      timer_nxt = timer_r;
      gap_nxt   = gap_r;
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               if (press_any_s) begin
                  sel_nxt   = lowest_idx(16'(press_s));
                  cnt_nxt   = 4'd1;
                  retry_nxt = 4'd0;
                  timer_nxt = 8'd0;
                  gap_nxt   = 1'b0;
                  state_nxt = (ARM_PRESSES == 1) ? ST_START : ST_ARMING;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_ARMING: begin
               if (press_sel_s) begin
                  cnt_nxt   = cnt_inc_s;
                  timer_nxt = 8'd0;
                  state_nxt = (cnt_inc_s >= 4'(ARM_PRESSES)) ? ST_START : ST_ARMING;
               end else if (press_any_s || timeout_s) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_IDLE;
               end else begin
                  timer_nxt = timer_inc_s;
               end
            end
            ST_START: begin
               timer_nxt = 8'd0;
               gap_nxt   = 1'b0;
               state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (done_sel_s) begin
                  state_nxt = ST_DONE;
               end else if (timeout_s) begin
                  // A restart holds start low for one tick before re-asserting.
                  if (RETRY_EN && (retry_r < 4'(MAX_RETRY))) begin
                     retry_nxt = (retry_r == 4'hF) ? retry_r : retry_r + 4'd1;
                     gap_nxt   = 1'b1;
                     state_nxt = ST_START;
                  end else begin
                     state_nxt = ST_FAIL;
                  end
               end else begin
                  timer_nxt = timer_inc_s;
               end
            end
            ST_DONE: begin
               if (press_sel_s) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
            ST_FAIL: begin
               if (press_any_s) begin
                  cnt_nxt   = 4'd0;
                  retry_nxt = 4'd0;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_FAIL;
               end
            end
            default: begin
               gap_nxt   = 1'b0;
               state_nxt = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt = state_r;
      end
   end

   // Output values computed from the next state so the registered outputs align with it.
   always_comb begin
      sel_mask_nxt_s = onehot(sel_nxt);
      if (((state_nxt == ST_START) && !gap_nxt) || (state_nxt == ST_WAIT) ||
          (state_nxt == ST_DONE)) begin
         start_nxt_s = sel_mask_nxt_s;
      end else begin
         start_nxt_s = {NCH{1'b0}};
      end
      busy_nxt_s  = (state_nxt == ST_ARMING) || (state_nxt == ST_START) ||
                    (state_nxt == ST_WAIT);
      fail_nxt_s  = (state_nxt == ST_FAIL);
      debug_nxt_s = 16'h0000;
      debug_nxt_s[DBG_STATE_LSB +: 4] = state_nxt;
      debug_nxt_s[DBG_SEL_LSB   +: 4] = sel_nxt;
      debug_nxt_s[DBG_RETRY_LSB +: 4] = retry_nxt;
      debug_nxt_s[DBG_PRESS_LSB +: 4] = cnt_nxt;
   end

   // State, counters and outputs; reset clears start_o without waiting for a tick.
   always_ff @(posedge clk_raw or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         sel_r   <= 4'd0;
         cnt_r   <= 4'd0;
         retry_r <= 4'd0;
         timer_r <= 8'd0;
         gap_r   <= 1'b0;
         start_o <= {NCH{1'b0}};
         busy    <= 1'b0;
         fail    <= 1'b0;
         debug   <= 16'h0000;
      end else begin
         state_r <= state_nxt;
         sel_r   <= sel_nxt;
         cnt_r   <= cnt_nxt;
         retry_r <= retry_nxt;
         timer_r <= timer_nxt;
         gap_r   <= gap_nxt;
         start_o <= start_nxt_s;
         busy    <= busy_nxt_s;
         fail    <= fail_nxt_s;
         debug   <= debug_nxt_s;
      end
   end

endmodule

// File: tb/tb_sd_start_ctrl.sv
// Bench for sd_start_ctrl: a tick-level model built from button sample history,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sd_start_ctrl;

   localparam int NCH      = 4;
   localparam int DIV_BITS = 4;
   localparam int ARM      = 2;
   localparam int TMO      = 10;
   localparam int MAXR     = 2;
   localparam int TICK_CYC = 16;
`ifdef SD_START_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic           clk_raw = 1'b0;
   logic           reset   = 1'b1;
   logic [NCH-1:0] pb_raw  = '0;
   logic [NCH-1:0] done_i  = '0;
   logic [NCH-1:0] start_o;
   logic           busy;
   logic           fail;
   logic [15:0]    debug;

   int n_tests = 0;
   int n_fail  = 0;

   int m_state = 0, m_sel = 0, m_cnt = 0, m_retry = 0, m_wait = 0, m_idle = 0;
   bit m_drop  = 1'b0;
   int cyc     = 0;
   logic [NCH-1:0] samp[$];

   sd_start_ctrl #(
      .DIV_BITS(DIV_BITS), .NCH(NCH), .ARM_PRESSES(ARM),
      .TIMEOUT_TICKS(TMO), .MAX_RETRY(MAXR)
   ) dut (
      .clk_raw (clk_raw),
      .reset   (reset),
      .pb_raw  (pb_raw),
      .done_i  (done_i),
      .start_o (start_o),
      .busy    (busy),
      .fail    (fail),
      .debug   (debug)
   );

   always #5 clk_raw = ~clk_raw;

   task automatic model_reset();
      m_state = 0; m_sel = 0; m_cnt = 0; m_retry = 0; m_wait = 0; m_idle = 0;
      m_drop = 1'b0; cyc = 0;
      samp.delete();
   endtask

   // One tick of the spec rules. A press on this tick means the button was
   // sampled 1 two ticks ago and 0 three ticks ago (both after reset).
   task automatic model_tick();
      logic [NCH-1:0] p, selm;
      int n;
      n = samp.size();
      p = '0;
      if (n >= 3) p = samp[n-2] & ~samp[n-3];
      samp.push_back(pb_raw);
      selm = '0;
      selm[m_sel] = 1'b1;
      case (m_state)
         0: if (p != 0) begin
               m_sel = 0;
               for (int i = NCH-1; i >= 0; i--) if (p[i]) m_sel = i;
               m_cnt = 1; m_retry = 0; m_idle = 0;
               m_state = (ARM == 1) ? 2 : 1;
            end
         1: if (p == selm) begin
               m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
               m_idle = 0;
               if (m_cnt >= ARM) m_state = 2;
            end else if (p != 0) begin
               m_state = 0; m_cnt = 0;
            end else begin
               m_idle++;
               if (m_idle >= TMO) begin m_state = 0; m_cnt = 0; end
            end
         2: begin m_state = 3; m_drop = 1'b0; m_wait = 0; end
         3: if (done_i[m_sel]) begin
               m_state = 4;
            end else begin
               m_wait++;
               if (m_wait >= TMO) begin
                  if (RETRY_EN && m_retry < MAXR) begin
                     m_retry++; m_drop = 1'b1; m_state = 2;
                  end else begin
                     m_state = 5;
                  end
               end
            end
         4: if (p == selm) begin m_state = 0; m_cnt = 0; end
         5: if (p != 0) begin m_state = 0; m_retry = 0; m_cnt = 0; end
         default: m_state = 0;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk_raw or posedge reset);
         if (reset) begin
            model_reset();
         end else begin
            cyc++;
            if (cyc % TICK_CYC == 0) model_tick();
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      logic [NCH-1:0] e_start;
      logic [15:0]    e_dbg;
      forever begin
         @(negedge clk_raw);
         if (!reset) begin
            e_start = '0;
            if ((m_state == 2 && !m_drop) || m_state == 3 || m_state == 4) e_start[m_sel] = 1'b1;
            e_dbg = {4'(m_state), 4'(m_sel), 4'(m_retry), 4'(m_cnt)};
            n_tests++;
            if (start_o !== e_start || busy !== (m_state >= 1 && m_state <= 3) ||
                fail !== (m_state == 5) || debug !== e_dbg) begin
               n_fail++;
               $display("FAIL model_cmp t=%0t start_o=%b exp %b busy=%b fail=%b debug=%h exp %h",
                        $time, start_o, e_start, busy, fail, debug, e_dbg);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * TICK_CYC) @(negedge clk_raw);
   endtask

   task automatic press(input logic [NCH-1:0] m);
      pb_raw = pb_raw | m;
      wait_ticks(3);
      pb_raw = pb_raw & ~m;
      wait_ticks(3);
   endtask

   initial begin
      repeat (3) @(negedge clk_raw);
      chk("rst_start", 16'(start_o), 16'h0000);
      chk("rst_busy",  16'(busy),    16'h0000);
      chk("rst_fail",  16'(fail),    16'h0000);
      chk("rst_debug", debug,        16'h0000);
      reset = 1'b0;
      wait_ticks(4);

      // Two presses on channel 2 launch a start.
      press(4'b0100);
      press(4'b0100);
      chk("arm2_start", 16'(start_o), 16'h0004);
      chk("arm2_sel",   16'(debug[11:8]), 16'h0002);
      chk("arm2_busy",  16'(busy), 16'h0001);
      done_i = 4'b0100;
      wait_ticks(2);
      done_i = 4'b0000;
      press(4'b0100);
      chk("arm2_idle", 16'(debug[15:12]), 16'h0000);

      // Press on a different channel while arming aborts.
      press(4'b0010);
      press(4'b1000);
      chk("abort_start", 16'(start_o), 16'h0000);
      chk("abort_cnt",   16'(debug[3:0]), 16'h0000);
      chk("abort_state", 16'(debug[15:12]), 16'h0000);

      // Simultaneous presses pick the lowest index; then the arming window expires.
      press(4'b0101);
      chk("lowest_sel",   16'(debug[11:8]), 16'h0000);
      chk("lowest_state", 16'(debug[15:12]), 16'h0001);
      wait_ticks(12);
      chk("arm_timeout", 16'(debug[15:12]), 16'h0000);

      // Done on another channel is ignored; done on sel completes.
      press(4'b0010);
      press(4'b0010);
      done_i = 4'b0001;
      wait_ticks(2);
      chk("done_other", 16'(debug[15:12]), 16'h0003);
      done_i = 4'b0011;
      wait_ticks(2);
      chk("done_state", 16'(debug[15:12]), 16'h0004);
      chk("done_start", 16'(start_o), 16'h0002);
      done_i = 4'b0000;
      press(4'b0010);
      chk("done_release", 16'(start_o), 16'h0000);
      chk("done_idle",    16'(debug[15:12]), 16'h0000);

      // Done never arrives: retries (when enabled) then FAIL.
      press(4'b0001);
      press(4'b0001);
      wait_ticks(12);
      chk("fail_first", 16'(fail), RETRY_EN ? 16'h0000 : 16'h0001);
      wait_ticks(25);
      chk("fail_final", 16'(fail), 16'h0001);
      chk("fail_retry", 16'(debug[7:4]), RETRY_EN ? 16'h0002 : 16'h0000);
      chk("fail_start", 16'(start_o), 16'h0000);
      press(4'b0100);
      chk("fail_exit", debug, 16'h0000);

      // Reset mid-WAIT drops start_o at once; a button held through reset is no press.
      press(4'b0100);
      press(4'b0100);
      chk("pre_rst_start", 16'(start_o), 16'h0004);
      @(negedge clk_raw);
      pb_raw = 4'b0100;
      #2 reset = 1'b1;
      #1 chk("rst_mid_start", 16'(start_o), 16'h0000);
      chk("rst_mid_busy", 16'(busy), 16'h0000);
      repeat (2) @(negedge clk_raw);
      reset = 1'b0;
      wait_ticks(10);
      chk("held_no_press", debug, 16'h0000);
      pb_raw = 4'b0000;
      wait_ticks(3);
      press(4'b0100);
      chk("after_rst_press", debug, 16'h1201);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
